// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   localparam int unsigned IFETCH_XLEN = 32;

   // Reset value held in the instruction register: addi x0, x0, 0.
   localparam logic [31:0] IFETCH_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } ifetch_state_t;

endpackage : ifetch_pkg

// File: rtl/ifetch_unit.sv
// Instruction fetch: one req/gnt/rvalid memory transaction per PC, held for the decoder under valid/ready.
// Optional misaligned-PC fault enabled by defining IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned XLEN = IFETCH_XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] pc,
   output logic            pc_adv,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            fault
);

   ifetch_state_t   r_state;
   ifetch_state_t   w_state_nxt;
   logic [XLEN-1:0] r_instr;
   logic            r_instr_valid;
   logic            w_capture;
   logic            w_misalign;

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign w_misalign = |pc[1:0];
`else
   logic w_pc_lo_unused;
   assign w_misalign     = 1'b0;
   assign w_pc_lo_unused = ^pc[1:0];
`endif

   // Next-state decode; gnt and rvalid only matter in their own states.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      unique case (r_state)
         REQ: begin
            if (w_misalign) begin
               w_state_nxt = FAULT;
            end else if (imem_gnt) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_capture   = 1'b1;
               w_state_nxt = VALID;
            end
         end
         VALID: begin
            if (instr_ready) begin
               w_state_nxt = REQ;
            end
         end
         FAULT: begin
            w_state_nxt = FAULT;
         end
         default: begin
            w_state_nxt = REQ;
         end
      endcase
   end

   // State, held instruction and registered valid; reset drops any in-flight fetch.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= REQ;
         r_instr       <= XLEN'(IFETCH_NOP);
         r_instr_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_instr_valid <= (w_state_nxt == VALID);
         if (w_capture) begin
            r_instr <= imem_rdata;
         end
      end
   end

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic r_fault;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= (w_state_nxt == FAULT);
      end
   end

   assign fault = r_fault;
`else
   assign fault = 1'b0;
`endif

   // Request is gated by reset_n so nothing is issued while the memory is held in reset.
   assign imem_req    = (r_state == REQ) && reset_n && !w_misalign;
   assign imem_addr   = {pc[XLEN-1:2], 2'b00};
   assign pc_adv      = (r_state == VALID) && instr_ready;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;

endmodule : ifetch_unit

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly downstream of the PC update register and upstream of the decoder. Takes the current `pc`, issues a request/grant/response transaction to instruction memory, holds the returned word for the decoder under a valid/ready handshake, and pulses `pc_adv` to let the PC register step only once the decoder has accepted the instruction. This allows multi-cycle instruction memories without changing the PC-update logic beyond an enable.

## Interface
Parameters:
- `XLEN`, 32: width of PC, address and instruction word.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `pc`, in, XLEN: current PC from the PC update stage.
- `pc_adv`, out, 1: one-cycle enable pulse; the PC register loads its next value on the following edge.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, XLEN: word-aligned fetch address, `{pc[XLEN-1:2], 2'b00}`.
- `imem_gnt`, in, 1: memory accepted the request this cycle.
- `imem_rvalid`, in, 1: `imem_rdata` valid this cycle.
- `imem_rdata`, in, XLEN: fetched instruction word.
- `instr`, out, XLEN: held instruction to the decoder.
- `instr_valid`, out, 1: `instr` is valid.
- `instr_ready`, in, 1: decoder accepts `instr`.
- `fault`, out, 1: misaligned-fetch fault, sticky.

## Operation
- FSM states: REQ, WAIT, VALID, FAULT.
- REQ: `imem_req`=1, `imem_addr` driven from `pc`. On `imem_gnt`, go to WAIT. Otherwise stay; request and address stay stable, because `pc` cannot change while `pc_adv`=0.
- WAIT: `imem_req`=0. On `imem_rvalid`, capture `imem_rdata` into `instr` and go to VALID.
- VALID: `instr_valid`=1. On `instr_ready`, pulse `pc_adv` in the same cycle and go to REQ. `instr` holds its value until the next capture.
- FAULT: reached only with the config macro set. `imem_req`=0, `instr_valid`=0, `fault`=1. Left only through reset.
- `imem_rvalid` outside WAIT is ignored; no capture, no state change.
- `imem_gnt` outside REQ is ignored.
- At most one outstanding transaction at any time.
- The memory shares `reset_n`, so no response from before a reset is ever delivered after it.

## Timing
- Reset values (state REQ once released): `imem_req`=0 while `reset_n`=0, `pc_adv`=0, `instr_valid`=0, `instr`=32'h00000013 (NOP), `fault`=0.
- Reset asserted in any state returns to REQ on the next edge. Any captured instruction or pending transaction is discarded.
- `imem_rvalid` is never asserted in the same cycle as its `imem_gnt`; the earliest response is the cycle after the grant.
- With immediate grant, next-cycle response and `instr_ready` tied high, throughput is 1 instruction per 3 cycles:
  - cycle 0: REQ and gnt.
  - cycle 1: WAIT and rvalid.
  - cycle 2: VALID and ready, `pc_adv`=1.
  - cycle 3: REQ on the new PC.
- `pc_adv` is combinational from state and `instr_ready`: `pc_adv = (state==VALID) & instr_ready`. It is never high for 2 consecutive cycles.
- `instr_valid` is registered (state==VALID). It drops in the cycle after the handshake.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - In REQ, if `pc[1:0]`≠0, no request is issued and the FSM goes to FAULT on the next edge.
  - `fault` then rises on that edge and stays high until reset.
- Not defined:
  - `pc[1:0]` is ignored (address is forced word-aligned) and FAULT is unreachable.
  - `fault` is tied 0.

## Structure
- Package `ifetch_pkg`:
  - state enum `ifetch_state_t` (REQ, WAIT, VALID, FAULT).
  - constant `IFETCH_NOP` = 32'h00000013.
- Single flat module; no sub-module is warranted. State register, instruction holding register and output decode all live in `ifetch_unit`.

## Test plan
- Reset, then release with `pc`=0, `imem_gnt`=1, `imem_rvalid` one cycle after grant with `imem_rdata`=32'h00500093, `instr_ready`=1:
  - `imem_addr`=0, `instr`=32'h00500093 with `instr_valid` for 1 cycle.
  - `pc_adv` pulses once per 3 cycles.
- Grant withheld 4 cycles at `pc`=0x10: `imem_req` stays high with `imem_addr`=0x10 for 5 cycles, and `pc_adv` stays 0.
- `instr_ready` low for 3 cycles in VALID:
  - `instr` and `instr_valid` stay stable and `pc_adv` stays 0.
  - `pc_adv` pulses exactly in the cycle `instr_ready` rises.
- Spurious `imem_rvalid` (rdata=32'hDEADBEEF) asserted in REQ and in VALID: `instr` is unchanged and no state change occurs.
- `reset_n` dropped during WAIT, then the response arrives:
  - Outputs return to their reset values and `instr`=NOP.
  - After release a fresh request is issued at the current `pc`.
- With `IFETCH_MISALIGN_CHECK_EN`, `pc`=0x6:
  - `imem_req` stays 0 and `fault`=1 from the next edge, staying high until reset.
- Without the macro, `pc`=0x6 gives `imem_addr`=0x4 and `fault`=0.
